// File: rtl/ir_ctrl_pkg.sv
// Shared types and constants for the IR command scheduler.
// Frame fields follow the NEC receiver output layout.
package ir_ctrl_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHeld = 1'b1
  } ir_state_e;

  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned CMD_MSB  = 7;
  localparam int unsigned CMD_LSB  = 0;

  localparam int unsigned ENTRY_W = 9;

  localparam logic [7:0]  DEF_ADDR_FILTER   = 8'h4D;
  localparam bit          DEF_FILTER_EN     = 1'b1;
  localparam int unsigned DEF_REPEAT_WINDOW = 5_500_000;
  localparam int unsigned DEF_REPEAT_SKIP   = 2;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;

  // Command byte in the upper bits, auto-repeat flag in bit 0.
  typedef struct packed {
    logic [7:0] code;
    logic       is_repeat;
  } cmd_entry_t;

endpackage

// File: rtl/ir_cmd_fifo.sv
// First-word-fall-through queue; pointers carry an extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module ir_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop & ~empty;
    // A pop frees the head slot in the same cycle, so a full queue still accepts.
    do_push = push & (~full | do_pop);
    rdata   = mem[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Qualifies NEC frames by address, turns repeat codes into auto-repeat commands
// after a skip count, and queues key events for a valid/ready consumer.
module ir_cmd_scheduler
  import ir_ctrl_pkg::*;
#(
  parameter logic [7:0]  ADDR_FILTER   = DEF_ADDR_FILTER,
  parameter bit          FILTER_EN     = DEF_FILTER_EN,
  parameter int unsigned REPEAT_WINDOW = DEF_REPEAT_WINDOW,
  parameter int unsigned REPEAT_SKIP   = DEF_REPEAT_SKIP,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] ir_data,
  input  logic        ir_frame_stb,
  input  logic        ir_repeat_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_code,
  output logic        cmd_is_repeat,
  output logic        key_held,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned   CntW    = (REPEAT_WINDOW > 1) ? $clog2(REPEAT_WINDOW) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(REPEAT_WINDOW - 1);

  ir_state_e       state_q;
  logic [CntW-1:0] win_cnt_q;
  logic [3:0]      rep_cnt_q;
  logic [7:0]      last_code_q;
  logic            rep_q;
  logic [7:0]      drop_cnt_q;

  logic       addr_ok;
  logic       frame_ok;
  logic       rep_evt;
  logic       skip_done;
  logic       push;
  logic       pop;
  logic       drop;
  logic       full;
  logic       empty;
  cmd_entry_t push_entry;
  cmd_entry_t head;
  logic       unused_bits;

  assign unused_bits = ^ir_data[19:16];

  always_comb begin
    addr_ok   = !FILTER_EN || (ir_data[ADDR_MSB:ADDR_LSB] == ADDR_FILTER);
    frame_ok  = ir_frame_stb & addr_ok;
    rep_evt   = ir_repeat_en & ~rep_q;
    skip_done = 32'(rep_cnt_q) >= REPEAT_SKIP;
    // A frame wins over a coincident repeat edge.
    push      = frame_ok | ((state_q == StHeld) & rep_evt & skip_done);
    if (frame_ok) begin
      push_entry = '{code: ir_data[CMD_MSB:CMD_LSB], is_repeat: 1'b0};
    end else begin
      push_entry = '{code: last_code_q, is_repeat: 1'b1};
    end
    pop  = ~empty & cmd_ready;
    drop = push & full & ~pop;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      win_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      last_code_q <= '0;
      rep_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      rep_q <= ir_repeat_en;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      case (state_q)
        StIdle: begin
          if (frame_ok) begin
            last_code_q <= ir_data[CMD_MSB:CMD_LSB];
            win_cnt_q   <= CntLoad;
            rep_cnt_q   <= '0;
            state_q     <= StHeld;
          end
        end
        StHeld: begin
          if (frame_ok) begin
            last_code_q <= ir_data[CMD_MSB:CMD_LSB];
            win_cnt_q   <= CntLoad;
            rep_cnt_q   <= '0;
          end else if (rep_evt) begin
            win_cnt_q <= CntLoad;
            if (!skip_done && (rep_cnt_q != 4'hF)) rep_cnt_q <= rep_cnt_q + 4'd1;
          end else if (win_cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            win_cnt_q <= win_cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ir_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ENTRY_W)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Head fields read as zero while the queue is empty so reset values are defined.
  always_comb begin
    cmd_valid     = ~empty;
    cmd_code      = cmd_valid ? head.code : 8'h00;
    cmd_is_repeat = cmd_valid & head.is_repeat;
    key_held      = (state_q == StHeld);
    drop_cnt      = drop_cnt_q;
  end

endmodule

// File: doc/ir_cmd_scheduler.md
# ir_cmd_scheduler

Command scheduler between the NEC receiver (`infrared_rcv`) and the application logic. It qualifies decoded frames by address and applies auto-repeat policy to NEC repeat codes. Accepted key events are queued in a small FIFO and presented on a valid/ready command port. It also tracks key-held state via a repeat timeout window and counts commands lost to back-pressure.

## Interface
Parameters:
- `ADDR_FILTER`, 8'h4D: NEC address accepted.
- `FILTER_EN`, 1: 1 = drop frames whose address ≠ `ADDR_FILTER`; 0 = accept all.
- `REPEAT_WINDOW`, 5_500_000: cycles (110 ms @ 50 MHz) a frame/repeat keeps the key held.
- `REPEAT_SKIP`, 2: number of initial repeat codes swallowed before auto-repeat output starts.
- `FIFO_DEPTH`, 4: command queue entries, power of two, ≥2.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `ir_data` in 20: receiver output; [15:8] address, [7:0] command, [19:16] ignored.
- `ir_frame_stb` in 1: one-cycle pulse from receiver, `ir_data` valid that cycle.
- `ir_repeat_en` in 1: receiver repeat flag (level); rising edge = one repeat code.
- `cmd_valid` out 1: queue head valid.
- `cmd_ready` in 1: consumer accepts head.
- `cmd_code` out 8: command byte of head.
- `cmd_is_repeat` out 1: head originates from auto-repeat.
- `key_held` out 1: a key is currently considered pressed.
- `drop_cnt` out 8: saturating count of events lost to a full queue.

## Operation
- All inputs synchronous to `sys_clk`; no synchronizers inside.
- Repeat event = `ir_repeat_en` & ~`rep_q` (`rep_q` registered, reset 0).
- FSM states: IDLE, HELD.
  - IDLE: `ir_frame_stb` with address pass → push {code,0}, latch `last_code`, load window counter with `REPEAT_WINDOW-1`, clear `rep_cnt`, → HELD. Repeat events ignored.
  - HELD: accepted frame → same as IDLE (new `last_code`, counter reload, `rep_cnt`=0). Repeat event → reload counter; if `rep_cnt` ≥ `REPEAT_SKIP` push {`last_code`,1}, else `rep_cnt`++ (saturating, 4 bits). Counter reaching 0 with no event → IDLE.
  - Address-rejected frame: ignored in both states, no state/counter change.
- `key_held` = (state == HELD).
- Frame strobe and repeat edge in same cycle: frame processed, repeat discarded.
- Queue: first-word-fall-through; pop when `cmd_valid & cmd_ready`.
- Push while full: event dropped, `drop_cnt`++ saturating at 255; FSM still updates. Push and pop same cycle when full: both succeed, no drop.
- `cmd_code`/`cmd_is_repeat` stable while `cmd_valid & ~cmd_ready`.

## Timing
- Reset values: `cmd_valid` 0, `cmd_code` 8'h00, `cmd_is_repeat` 0, `key_held` 0, `drop_cnt` 0, state IDLE, queue empty, `rep_q` 0.
- Latency: strobe/edge in cycle N → `cmd_valid` high in N+1 (empty queue).
- `key_held` rises in N+1 after accepted frame; falls exactly `REPEAT_WINDOW` cycles after the last accepted frame/repeat.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: queue flushed, counters cleared, `cmd_valid` deasserts asynchronously.

## Structure
- Package `ir_ctrl_pkg`: FSM state enum, `ir_data` field positions (ADDR_MSB/LSB, CMD_MSB/LSB), default parameter constants, queue entry width (9).
- Sub-module `ir_cmd_fifo`: synchronous FWFT FIFO, `FIFO_DEPTH` × 9 bits, full/empty flags, pointer wrap via extra MSB.
- Top holds FSM, edge detector, window counter, drop counter.

## Test plan
- Frame addr 8'h4D cmd 8'h80, `cmd_ready`=1 → one entry {8'h80,0} at N+1; `key_held` 1; falls after 5_500_000 cycles.
- Frame then 4 repeat edges at 108 ms spacing, `REPEAT_SKIP`=2 → outputs 8'h80(0), 8'h80(1), 8'h80(1); `key_held` stays 1.
- Frame addr 8'h12 with `FILTER_EN`=1 → no output, `key_held` 0; same with `FILTER_EN`=0 → entry output.
- `cmd_ready`=0, 6 accepted frames cmds 1..6 → queue holds 1..4, `drop_cnt`=2; releasing ready drains 1,2,3,4 in order.
- Frame strobe and repeat edge same cycle → exactly one non-repeat entry; repeat edge in IDLE → nothing.
- Assert `sys_rst_n`=0 with 3 queued entries in HELD → all outputs return to reset values immediately.
